bit_serial_adder: RTL and testbench
===================================

# bit_serial_adder

Bit-serial N-bit adder that sequences a single one-bit full-adder cell over WIDTH cycles, LSB first, with a registered carry between bits. It sits between a valid/ready producer and consumer. It trades throughput for area: one adder cell instead of WIDTH. Operands and carry-in are captured on acceptance, and the result is presented with a registered carry-out.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- busy  output  1  high only in RUN.
- out_valid  output  1  sum and cout are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result, a + b + cin modulo 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.

## Operation
- Internal state: state (IDLE, RUN, DONE), a_sr and b_sr (WIDTH bits), s_sr (WIDTH bits), carry (1 bit), cnt ($clog2(WIDTH) bits).
- One combinational full-adder cell computes s = a_sr[0]^b_sr[0]^carry and c = majority(a_sr[0], b_sr[0], carry).
- IDLE: in_ready=1. An edge with in_valid=1 loads a_sr<=a, b_sr<=b, carry<=cin, cnt<=0 and moves to RUN. With in_valid=0 the block stays in IDLE.
- RUN: on every edge, a_sr and b_sr shift right by 1, s_sr<={s, s_sr[WIDTH-1:1]}, carry<=c, cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: sum<={s, s_sr[WIDTH-1:1]}, cout<=c, and the state moves to DONE.
- DONE: out_valid=1, and sum and cout are held. An edge with out_ready=1 moves to IDLE. With out_ready=0 the block holds indefinitely.
- Inputs a, b and cin are sampled only on the acceptance edge. Changes afterwards have no effect.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- sum and cout change only on the final RUN edge and on reset. Between results they hold the last result.
- Arithmetic: {cout, sum} = a + b + cin exactly, evaluated as unsigned (WIDTH+1) bits. No overflow flag is produced.

## Timing
- Reset (asynchronous assert, any time): state=IDLE, in_ready=1, busy=0, out_valid=0, sum=0, cout=0. All internal registers are cleared.
- Reset during RUN or DONE aborts the operation. No out_valid is produced for the aborted operation, and the next acceptance starts clean.
- Latency: acceptance at edge k, then RUN for edges k+1 through k+WIDTH. out_valid is high after edge k+WIDTH.
- Result handshake: completes at the first edge with out_valid=1 and out_ready=1. in_ready rises after that edge.
- No same-cycle turnaround: DONE does not accept new operands. Minimum issue interval is WIDTH+2 cycles, when out_ready is held at 1.
- in_ready, busy and out_valid are decoded directly from the state register. They are glitch-free, with no combinational path from any input.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> outputs change immediately to in_ready=1, busy=0, out_valid=0, sum=0, cout=0, with no clock required.
- Basic add, WIDTH=8: a=8'h5A, b=8'h33, cin=0, with out_ready=1 -> busy for exactly 8 cycles, then out_valid=1 with sum=8'h8D and cout=0. in_ready returns 1 one edge later.
- Full carry ripple: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Backpressure: complete the add with out_ready=0 for 5 cycles while in_valid=1 and operands toggle -> out_valid stays 1, sum and cout stay stable, in_ready=0, and nothing is accepted. Raise out_ready -> the block returns to IDLE and then accepts the pending operands.
- Abort: accept a=8'hAA, b=8'h55, assert rst_n=0 after 3 RUN cycles, then release -> no out_valid and sum=0. A following a=8'h01, b=8'h01, cin=1 yields sum=8'h03, cout=0.
- Random/exhaustive: with WIDTH=4, apply all 512 combinations of (a, b, cin) back-to-back with random out_ready stalls -> every result equals a+b+cin, and each out_valid occurs exactly WIDTH edges after its acceptance.

Source files
------------

// File: rtl/bit_serial_adder_if.sv
// Valid/ready bus for bit_serial_adder.
//
// Groups the operand handshake (in_valid/in_ready, a, b, cin), the result
// handshake (out_valid/out_ready, sum, cout) and the busy status flag.
//   master : producer/consumer side; drives operands and out_ready.
//   slave  : adder side; drives in_ready, busy, out_valid, sum, cout.
interface bit_serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output out_ready,
    input  in_ready,
    input  busy,
    input  out_valid,
    input  sum,
    input  cout
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  out_ready,
    output in_ready,
    output busy,
    output out_valid,
    output sum,
    output cout
  );

endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder.
//
// A single one-bit full-adder cell is stepped over the operands LSB first,
// one bit per clock, with the carry held in a register between bits. Operands
// and carry-in are captured when accepted; the result {cout, sum} is
// registered and held until the consumer takes it.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of bit_serial_adder_if
//            in_valid/in_ready/a/b/cin  operand handshake (accepted in IDLE)
//            busy                       high while bits are being added
//            out_valid/out_ready        result handshake (offered in DONE)
//            sum/cout                   registered result a + b + cin
//
// Throughput: one result every WIDTH+2 cycles at best (accept, WIDTH RUN
// edges, one DONE edge). WIDTH must be at least 2.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  bit_serial_adder_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  // Only the upper WIDTH-1 partial-sum bits are ever read back: the bit that
  // would sit at position 0 is shifted out on the final edge unused.
  localparam int unsigned PartW = WIDTH - 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  logic [PartW-1:0]  s_sr_q, s_sr_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  // The one full-adder cell.
  logic fa_s;
  logic fa_c;

  always_comb begin
    fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    fa_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        // New bit enters at the top; the oldest partial bit drops off.
        s_sr_d  = PartW'({fa_s, s_sr_q} >> 1);
        carry_d = fa_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          sum_d   = {fa_s, s_sr_q};
          cout_d  = fa_c;
          state_d = StDone;
        end
      end

      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        // Unused encoding: fall back to a safe idle state.
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Status decoded straight from the state register: no input-to-output path.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q == StRun);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder: an 8-bit instance for the handshake,
// ripple, backpressure and abort cases, and a 4-bit instance swept over every
// (a, b, cin) combination with random result stalls.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(8)) bus8 ();
  bit_serial_adder_if #(.WIDTH(4)) bus4 ();

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  bit_serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the 8-bit instance with out_ready held high.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [8:0] exp);
    int n;
    int nb;
    bus8.a         = a;
    bus8.b         = b;
    bus8.cin       = cin;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b1;
    check_eq({tag, " in_ready"}, 32'(bus8.in_ready), 32'd1);
    step();
    bus8.in_valid = 1'b0;
    n  = 0;
    nb = 0;
    while (!bus8.out_valid && n < 40) begin
      if (bus8.busy) nb++;
      step();
      n++;
    end
    check_eq({tag, " latency"}, 32'(n), 32'd8);
    check_eq({tag, " busy_cycles"}, 32'(nb), 32'd8);
    check_eq({tag, " result"}, 32'({bus8.cout, bus8.sum}), 32'(exp));
    step();
    check_eq({tag, " in_ready_after"}, 32'(bus8.in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int seen;
    logic [8:0] v;
    logic [8:0] exp4;

    rst_n          = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.cin       = 1'b0;
    bus8.out_ready = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.cin       = 1'b0;
    bus4.out_ready = 1'b0;

    // Reset state before any clock edge.
    #2;
    check_eq("rst in_ready", 32'(bus8.in_ready), 32'd1);
    check_eq("rst busy", 32'(bus8.busy), 32'd0);
    check_eq("rst out_valid", 32'(bus8.out_valid), 32'd0);
    check_eq("rst result", 32'({bus8.cout, bus8.sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run8("basic", 8'h5A, 8'h33, 1'b0, 9'h08D);
    run8("ripple1", 8'hFF, 8'h01, 1'b0, 9'h100);
    run8("ripple2", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // Backpressure: result held while new operands wait.
    bus8.out_ready = 1'b0;
    bus8.a         = 8'h12;
    bus8.b         = 8'h34;
    bus8.cin       = 1'b1;
    bus8.in_valid  = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    n = 0;
    while (!bus8.out_valid && n < 40) begin
      step();
      n++;
    end
    check_eq("bp latency", 32'(n), 32'd8);
    check_eq("bp result", 32'({bus8.cout, bus8.sum}), 32'h047);
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = 1'b1;
      bus8.a        = 8'(i * 8'h11);
      bus8.b        = 8'(8'hF0 - i);
      bus8.cin      = i[0];
      step();
      check_eq("bp hold out_valid", 32'(bus8.out_valid), 32'd1);
      check_eq("bp hold result", 32'({bus8.cout, bus8.sum}), 32'h047);
      check_eq("bp hold in_ready", 32'(bus8.in_ready), 32'd0);
    end
    bus8.a         = 8'h10;
    bus8.b         = 8'h20;
    bus8.cin       = 1'b0;
    bus8.out_ready = 1'b1;
    step();
    check_eq("bp release in_ready", 32'(bus8.in_ready), 32'd1);
    check_eq("bp release out_valid", 32'(bus8.out_valid), 32'd0);
    step();
    bus8.in_valid = 1'b0;
    check_eq("bp pending busy", 32'(bus8.busy), 32'd1);
    n = 0;
    while (!bus8.out_valid && n < 40) begin
      step();
      n++;
    end
    check_eq("bp pending latency", 32'(n), 32'd8);
    check_eq("bp pending result", 32'({bus8.cout, bus8.sum}), 32'h030);
    step();

    // Abort mid-run with an asynchronous reset.
    bus8.a        = 8'hAA;
    bus8.b        = 8'h55;
    bus8.cin      = 1'b0;
    bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort in_ready", 32'(bus8.in_ready), 32'd1);
    check_eq("abort busy", 32'(bus8.busy), 32'd0);
    check_eq("abort out_valid", 32'(bus8.out_valid), 32'd0);
    check_eq("abort result", 32'({bus8.cout, bus8.sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus8.out_valid) seen++;
    end
    check_eq("abort no out_valid", 32'(seen), 32'd0);
    check_eq("abort sum held zero", 32'(bus8.sum), 32'd0);
    run8("after_abort", 8'h01, 8'h01, 1'b1, 9'h003);

    // Exhaustive 4-bit sweep with random result stalls.
    for (int k = 0; k < 512; k++) begin
      v    = 9'(k);
      exp4 = 9'(v[3:0]) + 9'(v[7:4]) + 9'(v[8]);
      bus4.a        = v[3:0];
      bus4.b        = v[7:4];
      bus4.cin      = v[8];
      bus4.in_valid = 1'b1;
      step();
      bus4.in_valid = 1'b0;
      n = 0;
      while (!bus4.out_valid && n < 40) begin
        step();
        n++;
      end
      check_eq("w4 latency", 32'(n), 32'd4);
      check_eq("w4 result", 32'({bus4.cout, bus4.sum}), 32'(exp4));
      repeat ($urandom_range(0, 2)) step();
      bus4.out_ready = 1'b1;
      step();
      bus4.out_ready = 1'b0;
    end
    check_eq("w4 final in_ready", 32'(bus4.in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
